// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the FP32 multiplier back end:
//   - IEEE-754 single-precision field widths and special encodings
//   - normaliser/rounder FSM state type
//   - result exception-flag bundle
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_BIAS    = 127;
  localparam int EXP_MAX     = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;
  localparam int MANT_PROD_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even of a 23-bit fraction.
// Ports:
//   frac     - truncated fraction
//   lsb      - least significant kept bit (tie breaker)
//   guard    - first discarded bit
//   sticky   - OR of all bits below guard
//   frac_rnd - rounded fraction (wraps to zero on carry)
//   carry    - rounding overflowed the fraction; caller bumps the exponent
//   inexact  - any discarded bit was nonzero
// ---------------------------------------------------------------------------
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac,
  input  logic                 lsb,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [FP_FRAC_W-1:0] frac_rnd,
  output logic                 carry,
  output logic                 inexact
);

  // Returns {carry, rounded fraction}. A tie (guard set, nothing below)
  // rounds up only when the kept lsb is odd.
  function automatic logic [FP_FRAC_W:0] rne_round(
    input logic [FP_FRAC_W-1:0] f,
    input logic                 l,
    input logic                 g,
    input logic                 s
  );
    logic up;
    up = g & (s | l);
    return {1'b0, f} + {{FP_FRAC_W{1'b0}}, up};
  endfunction

  assign {carry, frac_rnd} = rne_round(frac, lsb, guard, sticky);
  assign inexact           = guard | sticky;

endmodule

// File: rtl/fp_norm_round.sv
// ---------------------------------------------------------------------------
// fp_norm_round
// Back end of the FP32 multiplier: takes the raw 48-bit significand product
// (binary point between bits 46 and 45) with a signed biased exponent,
// normalises it one bit per cycle, rounds to nearest-even and packs an
// IEEE-754 single. Overflow saturates to infinity, results with exponent
// <= 0 flush to signed zero. Single-entry: one operation in flight.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid / in_ready      - upstream handshake (ready only when idle)
//   in_sign, in_exp, in_mant - product sign, biased exponent, significand
//   in_zero, in_inf, in_nan  - operand class flags
//   out_valid / out_ready    - downstream handshake
//   out_result               - packed FP32 result
//   out_overflow             - saturated to infinity
//   out_underflow            - flushed to zero
//   out_inexact              - guard or sticky nonzero at rounding
// ---------------------------------------------------------------------------
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W           = 10,
  parameter bit FLUSH_SUBNORMAL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [MANT_PROD_W-1:0]  in_mant,
  input  logic                    in_zero,
  input  logic                    in_inf,
  input  logic                    in_nan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  // Results below the normal range always flush to signed zero.
  if (!FLUSH_SUBNORMAL) begin : g_no_subnormal
    $error("fp_norm_round: FLUSH_SUBNORMAL=0 is not supported");
  end

  // Exponent inputs reach 3*bias and normalisation moves them by up to 47,
  // so the signed exponent must hold that without wrapping.
  if ((1 << (EXP_W - 1)) <= (3 * EXP_BIAS + MANT_PROD_W)) begin : g_exp_narrow
    $error("fp_norm_round: EXP_W too narrow for exponent range");
  end

  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_OVF  = EXP_W'(EXP_MAX);

  state_t                    state;
  logic                      sign_q;
  logic signed [EXP_W-1:0]   exp_q;
  logic [MANT_PROD_W-1:0]    mant_q;
  logic                      sticky_q;
  flags_t                    flags_q;

  // Special-operand decode on the incoming product.
  logic        is_special;
  logic [31:0] special_result;

  always_comb begin
    is_special     = 1'b1;
    special_result = '0;
    if (in_nan || (in_inf && in_zero)) begin
      special_result = QNAN;
    end else if (in_inf) begin
      special_result = {in_sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
    end else if (in_zero || (in_mant == '0)) begin
      special_result = {in_sign, 31'b0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Rounding fields taken from the normalised significand (hidden bit 46).
  logic [FP_FRAC_W-1:0]    frac_rnd;
  logic                    rnd_carry;
  logic                    rnd_inexact;
  logic                    sticky_all;
  logic signed [EXP_W-1:0] carry_ext;
  logic signed [EXP_W-1:0] exp_rnd;

  assign sticky_all = sticky_q | (|mant_q[21:0]);
  assign carry_ext  = {{(EXP_W-1){1'b0}}, rnd_carry};
  assign exp_rnd    = exp_q + carry_ext;

  fp_round_rne u_round (
    .frac     (mant_q[45:23]),
    .lsb      (mant_q[23]),
    .guard    (mant_q[22]),
    .sticky   (sticky_all),
    .frac_rnd (frac_rnd),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign in_ready      = (state == IDLE);
  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
  assign out_inexact   = flags_q.inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      sticky_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
    end else begin
      case (state)
        // Capture: specials resolve immediately, everything else normalises.
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_sign;
            exp_q    <= in_exp;
            mant_q   <= in_mant;
            sticky_q <= 1'b0;
            if (is_special) begin
              out_result <= special_result;
              flags_q    <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        // Normalise: one shift per cycle until the hidden bit sits at 46,
        // or the exponent bottoms out (left shifts stop at exp == 1).
        NORM: begin
          if (mant_q[47]) begin
            mant_q   <= mant_q >> 1;
            sticky_q <= sticky_q | mant_q[0];
            exp_q    <= exp_q + EXP_ONE;
          end else if (!mant_q[46] && (exp_q > EXP_ONE)) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end else begin
            state <= ROUND;
          end
        end

        // Round and pack; range checks use the post-rounding exponent.
        ROUND: begin
          flags_q.inexact <= rnd_inexact;
          if (exp_rnd >= EXP_OVF) begin
            out_result        <= {sign_q, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
            flags_q.overflow  <= 1'b1;
            flags_q.underflow <= 1'b0;
          end else if ((exp_rnd <= EXP_ZERO) || !mant_q[46]) begin
            out_result        <= {sign_q, 31'b0};
            flags_q.overflow  <= 1'b0;
            flags_q.underflow <= 1'b1;
          end else begin
            out_result        <= {sign_q, exp_rnd[FP_EXP_W-1:0], frac_rnd};
            flags_q.overflow  <= 1'b0;
            flags_q.underflow <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        // Hold result until the downstream handshake completes.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp_norm_round
// Directed self-checking bench for fp_norm_round. Latency is counted in
// clock edges starting with the accepting edge (specials = 1, a product
// already normalised at bit 46 = 3).
// ---------------------------------------------------------------------------
module tb_fp_norm_round;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_sign = 1'b0;
  logic signed [9:0]  in_exp = '0;
  logic [47:0]        in_mant = '0;
  logic               in_zero = 1'b0;
  logic               in_inf = 1'b0;
  logic               in_nan = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_result;
  logic               out_overflow;
  logic               out_underflow;
  logic               out_inexact;

  int checks = 0;
  int errors = 0;

  // {sign, exp, mant, zero, inf, nan, expected result, {ovf,unf,inx}, latency}
  typedef struct packed {
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    logic        z;
    logic        i;
    logic        n;
    logic [31:0] res;
    logic [2:0]  flg;
    logic [7:0]  lat;
  } vec_t;

  fp_norm_round #(.EXP_W(10), .FLUSH_SUBNORMAL(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_zero       (in_zero),
    .in_inf        (in_inf),
    .in_nan        (in_nan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one operand set for exactly one accepting edge.
  task automatic send(input vec_t v);
    int wait_cnt = 0;
    while (in_ready !== 1'b1 && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    in_sign  = v.s;
    in_exp   = v.e;
    in_mant  = v.m;
    in_zero  = v.z;
    in_inf   = v.i;
    in_nan   = v.n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_zero  = 1'b0;
    in_inf   = 1'b0;
    in_nan   = 1'b0;
  endtask

  // Count edges (including the accepting one) until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset out_valid: got %b, expected 0", out_valid);
    end
    checks++;
    if (out_result !== 32'h0) begin
      errors++; $display("FAIL reset out_result: got %h, expected 00000000", out_result);
    end
    checks++;
    if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      errors++; $display("FAIL reset flags: got %b, expected 000",
                         {out_overflow, out_underflow, out_inexact});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_normal();
    vec_t v[4];
    int lat;
    v[0] = '{1'b0, 10'd128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 3'b000, 8'd3};
    v[1] = '{1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000, 8'd4};
    v[2] = '{1'b0, 10'd127, 48'h1000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h3E80_0000, 3'b000, 8'd5};
    v[3] = '{1'b1, 10'd130, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hC100_0000, 3'b000, 8'd3};
    foreach (v[k]) begin
      send(v[k]);
      wait_out(lat);
      checks++;
      if (out_valid !== 1'b1 || lat != int'(v[k].lat)) begin
        errors++; $display("FAIL normal[%0d] latency: got %0d (valid=%b), expected %0d",
                           k, lat, out_valid, v[k].lat);
      end
      checks++;
      if (out_result !== v[k].res) begin
        errors++; $display("FAIL normal[%0d] result: got %h, expected %h", k, out_result, v[k].res);
      end
      checks++;
      if ({out_overflow, out_underflow, out_inexact} !== v[k].flg) begin
        errors++; $display("FAIL normal[%0d] flags: got %b, expected %b", k,
                           {out_overflow, out_underflow, out_inexact}, v[k].flg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rounding();
    vec_t v[5];
    int lat;
    // ties to even, above half, carry into exponent, sticky from right shift
    v[0] = '{1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001, 8'd3};
    v[1] = '{1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001, 8'd3};
    v[2] = '{1'b0, 10'd127, 48'h4000_0040_0001, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 3'b001, 8'd3};
    v[3] = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001, 8'd3};
    v[4] = '{1'b0, 10'd127, 48'h8000_0080_0001, 1'b0, 1'b0, 1'b0, 32'h4000_0001, 3'b001, 8'd4};
    foreach (v[k]) begin
      send(v[k]);
      wait_out(lat);
      checks++;
      if (out_valid !== 1'b1 || lat != int'(v[k].lat)) begin
        errors++; $display("FAIL round[%0d] latency: got %0d (valid=%b), expected %0d",
                           k, lat, out_valid, v[k].lat);
      end
      checks++;
      if (out_result !== v[k].res) begin
        errors++; $display("FAIL round[%0d] result: got %h, expected %h", k, out_result, v[k].res);
      end
      checks++;
      if ({out_overflow, out_underflow, out_inexact} !== v[k].flg) begin
        errors++; $display("FAIL round[%0d] flags: got %b, expected %b", k,
                           {out_overflow, out_underflow, out_inexact}, v[k].flg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_range();
    vec_t v[8];
    int lat;
    v[0] = '{1'b0, 10'd300,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b100, 8'd3};
    v[1] = '{1'b1, 10'h3F6,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b010, 8'd3}; // exp -10
    v[2] = '{1'b0, 10'd254,  48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101, 8'd3};
    v[3] = '{1'b0, 10'd2,    48'h1000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b010, 8'd4};
    v[4] = '{1'b0, 10'd255,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b100, 8'd3};
    v[5] = '{1'b0, 10'd254,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 3'b000, 8'd3};
    v[6] = '{1'b0, 10'd1,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000, 8'd3};
    v[7] = '{1'b1, 10'd0,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b010, 8'd3};
    foreach (v[k]) begin
      send(v[k]);
      wait_out(lat);
      checks++;
      if (out_valid !== 1'b1 || lat != int'(v[k].lat)) begin
        errors++; $display("FAIL range[%0d] latency: got %0d (valid=%b), expected %0d",
                           k, lat, out_valid, v[k].lat);
      end
      checks++;
      if (out_result !== v[k].res) begin
        errors++; $display("FAIL range[%0d] result: got %h, expected %h", k, out_result, v[k].res);
      end
      checks++;
      if ({out_overflow, out_underflow, out_inexact} !== v[k].flg) begin
        errors++; $display("FAIL range[%0d] flags: got %b, expected %b", k,
                           {out_overflow, out_underflow, out_inexact}, v[k].flg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_specials();
    vec_t v[5];
    int lat;
    v[0] = '{1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000, 8'd1};
    v[1] = '{1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000, 8'd1};
    v[2] = '{1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000, 8'd1};
    v[3] = '{1'b1, 10'd127, 48'h6000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 8'd1};
    v[4] = '{1'b0, 10'd127, 48'h0000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, 8'd1};
    foreach (v[k]) begin
      send(v[k]);
      wait_out(lat);
      checks++;
      if (out_valid !== 1'b1 || lat != int'(v[k].lat)) begin
        errors++; $display("FAIL special[%0d] latency: got %0d (valid=%b), expected %0d",
                           k, lat, out_valid, v[k].lat);
      end
      checks++;
      if (out_result !== v[k].res) begin
        errors++; $display("FAIL special[%0d] result: got %h, expected %h", k, out_result, v[k].res);
      end
      checks++;
      if ({out_overflow, out_underflow, out_inexact} !== v[k].flg) begin
        errors++; $display("FAIL special[%0d] flags: got %b, expected %b", k,
                           {out_overflow, out_underflow, out_inexact}, v[k].flg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    int lat;
    v = '{1'b0, 10'd128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 3'b000, 8'd3};
    out_ready = 1'b0;
    send(v);
    wait_out(lat);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin
      errors++; $display("FAIL bp first result: got %h (valid=%b), expected 40400000",
                         out_result, out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        // a competing request while stalled must not be taken
        in_sign = 1'b1; in_inf = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin
        errors++; $display("FAIL bp hold cycle %0d: got %h (valid=%b), expected 40400000",
                           c, out_result, out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp in_ready cycle %0d: got %b, expected 0", c, in_ready);
      end
    end
    in_valid = 1'b0; in_inf = 1'b0; in_sign = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp release: got valid=%b ready=%b, expected valid=0 ready=1",
                         out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL bp ignored request cycle %0d: got valid=%b result=%h, expected valid=0",
                           c, out_valid, out_result);
      end
    end
  endtask

  task automatic test_reset_mid_norm();
    vec_t v;
    int lat;
    // lone bit 0 needs dozens of left shifts, so NORM is busy for a while
    v = '{1'b0, 10'd100, 48'h0000_0000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 8'd0};
    send(v);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++; $display("FAIL rst mid-norm outputs: got valid=%b result=%h, expected 0/00000000",
                         out_valid, out_result);
    end
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst mid-norm recovery: got ready=%b valid=%b, expected 1/0",
                         in_ready, out_valid);
    end
    v = '{1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b000, 8'd3};
    send(v);
    wait_out(lat);
    checks++;
    if (out_valid !== 1'b1 || lat != 3 || out_result !== 32'h3F80_0000) begin
      errors++; $display("FAIL rst mid-norm next op: got %h lat %0d (valid=%b), expected 3F800000 lat 3",
                         out_result, lat, out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_rounding();
    test_range();
    test_specials();
    test_backpressure();
    test_reset_mid_norm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
